reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer.sv | 150 +++++++++++++++
 tb/tb_reset_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises hardware reset requests, stretches each reset event
// to a minimum hold time, and exposes a sticky CAUSE register and a software trigger over TL-UL.
module rstseq_sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [1:0] sync_pipe;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], d};

  assign q = sync_pipe[1];
endmodule

module reset_sequencer #(
  parameter int NSRC  = 2,
  parameter int HOLD  = 16,
  parameter int TL_RS = 4,
  parameter int TL_SZ = 4
)(
  input  logic             rstseq_clock_i,
  input  logic             rstseq_reset_ni,
  input  logic [NSRC-1:0]  req_i,
  output logic             sys_reset_o,
  input  logic [2:0]       rstseq_a_opcode,
  input  logic [TL_SZ-1:0] rstseq_a_size,
  input  logic [TL_RS-1:0] rstseq_a_source,
  input  logic [3:0]       rstseq_a_address,
  input  logic [31:0]      rstseq_a_data,
  input  logic             rstseq_a_valid,
  output logic             rstseq_a_ready,
  output logic [2:0]       rstseq_d_opcode,
  output logic [TL_SZ-1:0] rstseq_d_size,
  output logic [TL_RS-1:0] rstseq_d_source,
  output logic             rstseq_d_denied,
  output logic [31:0]      rstseq_d_data,
  output logic             rstseq_d_valid,
  input  logic             rstseq_d_ready
);
  localparam int CW = $clog2(HOLD);
  localparam int CZ = NSRC + 2;
  localparam logic [CW-1:0] CNT_INIT = CW'(HOLD - 1);

  typedef enum logic [1:0] {ST_HOLD, ST_WAIT_CLR, ST_RUN} state_t;

  typedef struct packed {
    logic [2:0]       opcode;
    logic [TL_SZ-1:0] size;
    logic [TL_RS-1:0] source;
    logic             denied;
    logic [31:0]      data;
  } tl_rsp_t;

  logic [NSRC-1:0] sreq;

  for (genvar i = 0; i < NSRC; i++) begin : g_sync
    rstseq_sync_bit u_sync (
      .clk   (rstseq_clock_i),
      .rst_n (rstseq_reset_ni),
      .d     (req_i[i]),
      .q     (sreq[i])
    );
  end

  // TL-UL decode
  logic    d_valid;
  tl_rsp_t rsp_q, rsp_d;
  logic    a_fire, is_get, is_put, addr_cause, addr_trig, denied, sw_trig;
  logic [CZ-1:0] cause, cause_clr, cause_set;

  assign rstseq_a_ready = !d_valid || rstseq_d_ready;
  assign a_fire     = rstseq_a_valid && rstseq_a_ready;
  assign is_get     = rstseq_a_opcode == 3'd4;
  assign is_put     = (rstseq_a_opcode == 3'd0) || (rstseq_a_opcode == 3'd1);
  assign addr_cause = rstseq_a_address == 4'h0;
  assign addr_trig  = rstseq_a_address == 4'h4;
  assign denied     = !(is_get || is_put) || !(addr_cause || addr_trig);
  assign sw_trig    = a_fire && !denied && is_put && addr_trig && (rstseq_a_data[7:0] == 8'h5A);
  assign cause_clr  = (a_fire && !denied && is_put && addr_cause) ? rstseq_a_data[CZ-1:0] : '0;
  assign cause_set  = {sw_trig, sreq, 1'b0};

  always_comb begin
    rsp_d        = '0;
    rsp_d.opcode = is_get ? 3'd1 : 3'd0;
    rsp_d.size   = rstseq_a_size;
    rsp_d.source = rstseq_a_source;
    rsp_d.denied = denied;
    rsp_d.data   = (!denied && is_get && addr_cause) ? 32'(cause) : 32'd0;
  end

  always_ff @(posedge rstseq_clock_i or negedge rstseq_reset_ni) begin
    if (!rstseq_reset_ni) begin
      d_valid <= 1'b0;
      rsp_q   <= '0;
    end else if (a_fire) begin
      d_valid <= 1'b1;
      rsp_q   <= rsp_d;
    end else if (rstseq_d_ready) begin
      d_valid <= 1'b0;
    end
  end

  assign rstseq_d_valid  = d_valid;
  assign rstseq_d_opcode = rsp_q.opcode;
  assign rstseq_d_size   = rsp_q.size;
  assign rstseq_d_source = rsp_q.source;
  assign rstseq_d_denied = rsp_q.denied;
  assign rstseq_d_data   = rsp_q.data;

  // Sticky cause: a set in the same cycle as a W1C clear wins
  always_ff @(posedge rstseq_clock_i or negedge rstseq_reset_ni)
    if (!rstseq_reset_ni) cause <= CZ'(1);
    else                  cause <= (cause & ~cause_clr) | cause_set;

  // Sequencer FSM
  state_t        state, state_nxt;
  logic [CW-1:0] cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HOLD:     if (cnt == '0) state_nxt = ST_WAIT_CLR;
      ST_WAIT_CLR: if (sreq == '0) state_nxt = ST_RUN;
      ST_RUN:      if (sreq != '0 || sw_trig) state_nxt = ST_HOLD;
      default:     state_nxt = ST_HOLD;
    endcase
  end

  always_ff @(posedge rstseq_clock_i or negedge rstseq_reset_ni) begin
    if (!rstseq_reset_ni) begin
      state       <= ST_HOLD;
      cnt         <= CNT_INIT;
      sys_reset_o <= 1'b1;
    end else begin
      case (state)
        ST_HOLD: if (cnt != '0) cnt <= cnt - 1'b1;
        ST_RUN:  if (state_nxt == ST_HOLD) cnt <= CNT_INIT;
        default: ;
      endcase
      state       <= state_nxt;
      sys_reset_o <= (state_nxt != ST_RUN);
    end
  end

  logic unused_a_data;
  assign unused_a_data = ^rstseq_a_data;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed TL vector table, hand-written reset corner sequences,
// and randomized traffic checked every cycle against an elapsed-time reference model.
module tb_reset_sequencer;
  localparam int NSRC = 2, HOLD = 16, TL_RS = 4, TL_SZ = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  req_i = '0;
  logic        sys_reset_o;
  logic [2:0]  a_opcode = '0;
  logic [3:0]  a_size = '0, a_source = '0, a_address = '0;
  logic [31:0] a_data = '0;
  logic        a_valid = 1'b0, a_ready;
  logic [2:0]  d_opcode;
  logic [3:0]  d_size, d_source;
  logic        d_denied, d_valid;
  logic [31:0] d_data;
  logic        d_ready = 1'b1;

  int total = 0, bad = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.NSRC(NSRC), .HOLD(HOLD), .TL_RS(TL_RS), .TL_SZ(TL_SZ)) dut (
    .rstseq_clock_i(clk), .rstseq_reset_ni(rst_n), .req_i(req_i), .sys_reset_o(sys_reset_o),
    .rstseq_a_opcode(a_opcode), .rstseq_a_size(a_size), .rstseq_a_source(a_source),
    .rstseq_a_address(a_address), .rstseq_a_data(a_data), .rstseq_a_valid(a_valid),
    .rstseq_a_ready(a_ready), .rstseq_d_opcode(d_opcode), .rstseq_d_size(d_size),
    .rstseq_d_source(d_source), .rstseq_d_denied(d_denied), .rstseq_d_data(d_data),
    .rstseq_d_valid(d_valid), .rstseq_d_ready(d_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a reset episode starts when the system is running and a synchronised
  // request or software trigger appears; it may end once HOLD+1 edges have elapsed and
  // every synchronised request is idle.
  bit          m_out, m_pend, m_den;
  int          m_k, m_start;
  logic [1:0]  m_r1, m_r2;
  logic [3:0]  m_cause, m_sz, m_src;
  logic [2:0]  m_op;
  logic [31:0] m_data;

  task automatic model_reset();
    m_out = 1; m_pend = 0; m_k = 0; m_start = 0; m_r1 = '0; m_r2 = '0;
    m_cause = 4'h1; m_op = '0; m_sz = '0; m_src = '0; m_den = 0; m_data = '0;
  endtask

  task automatic model_step();
    logic [1:0] sreq;
    logic [3:0] clr;
    bit acc, put, get, ok, sw;
    m_k++;
    sreq = m_r2;
    acc  = a_valid && (!m_pend || d_ready);
    put  = (a_opcode == 3'd0) || (a_opcode == 3'd1);
    get  = (a_opcode == 3'd4);
    ok   = (put || get) && (a_address == 4'h0 || a_address == 4'h4);
    sw   = acc && ok && put && a_address == 4'h4 && a_data[7:0] == 8'h5A;
    clr  = (acc && ok && put && a_address == 4'h0) ? a_data[3:0] : 4'h0;
    if (m_pend && d_ready) m_pend = 0;
    if (acc) begin
      m_pend = 1;
      m_op   = get ? 3'd1 : 3'd0;
      m_sz   = a_size;
      m_src  = a_source;
      m_den  = !ok;
      m_data = (ok && get && a_address == 4'h0) ? {28'd0, m_cause} : 32'd0;
    end
    m_cause = (m_cause & ~clr) | {sw, sreq, 1'b0};
    if (!m_out) begin
      if (sreq != 2'b00 || sw) begin m_out = 1; m_start = m_k; end
    end else if (m_k - m_start >= HOLD + 1 && sreq == 2'b00) begin
      m_out = 0;
    end
    m_r2 = m_r1;
    m_r1 = req_i;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("sys_reset", 32'(sys_reset_o), 32'(m_out));
      chk("a_ready", 32'(a_ready), 32'(!m_pend || d_ready));
      chk("d_valid", 32'(d_valid), 32'(m_pend));
      if (m_pend || !rst_n) begin
        chk("d_opcode", 32'(d_opcode), 32'(m_op));
        chk("d_size", 32'(d_size), 32'(m_sz));
        chk("d_source", 32'(d_source), 32'(m_src));
        chk("d_denied", 32'(d_denied), 32'(m_den));
        chk("d_data", d_data, m_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (sys_reset_o && n < 100) begin n++; tick(); end
  endtask

  task automatic tl_xfer(input logic [2:0] op, input logic [3:0] addr, input logic [31:0] data,
                         output logic [2:0] rop, output logic rden, output logic [31:0] rdata);
    int n;
    logic [3:0] sz, src;
    sz = 4'($urandom); src = 4'($urandom);
    a_opcode = op; a_address = addr; a_data = data; a_size = sz; a_source = src;
    a_valid = 1; d_ready = 1;
    n = 0;
    while (!a_ready && n < 20) begin tick(); n++; end
    tick();
    a_valid = 0;
    n = 0;
    while (!d_valid && n < 20) begin tick(); n++; end
    chk("xfer_in_time", 32'(n < 20), 32'd1);
    chk("xfer_size_echo", 32'(d_size), 32'(sz));
    chk("xfer_source_echo", 32'(d_source), 32'(src));
    rop = d_opcode; rden = d_denied; rdata = d_data;
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [2:0]  e_op;
    logic        e_den;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [13];
  logic [2:0] ops [6];
  logic [3:0] addrs [4];

  initial begin
    int n, hold_cnt;
    logic [2:0] rop;
    logic rden;
    logic [31:0] rdata;

    tbl[0]  = '{3'd4, 4'h0, 32'h0,        3'd1, 1'b0, 32'h3};
    tbl[1]  = '{3'd4, 4'h4, 32'h0,        3'd1, 1'b0, 32'h0};
    tbl[2]  = '{3'd4, 4'h8, 32'h0,        3'd1, 1'b1, 32'h0};
    tbl[3]  = '{3'd2, 4'h0, 32'hF,        3'd0, 1'b1, 32'h0};
    tbl[4]  = '{3'd4, 4'h1, 32'h0,        3'd1, 1'b1, 32'h0};
    tbl[5]  = '{3'd0, 4'h4, 32'h5B,       3'd0, 1'b0, 32'h0};
    tbl[6]  = '{3'd1, 4'h0, 32'h1,        3'd0, 1'b0, 32'h0};
    tbl[7]  = '{3'd4, 4'h0, 32'h0,        3'd1, 1'b0, 32'h2};
    tbl[8]  = '{3'd0, 4'h0, 32'hFFFFFFFF, 3'd0, 1'b0, 32'h0};
    tbl[9]  = '{3'd4, 4'h0, 32'h0,        3'd1, 1'b0, 32'h0};
    tbl[10] = '{3'd0, 4'hC, 32'h5A,       3'd0, 1'b1, 32'h0};
    tbl[11] = '{3'd7, 4'h4, 32'h5A,       3'd0, 1'b1, 32'h0};
    tbl[12] = '{3'd4, 4'h0, 32'h0,        3'd1, 1'b0, 32'h0};
    ops   = '{3'd0, 3'd1, 3'd4, 3'd4, 3'd2, 3'd5};
    addrs = '{4'h0, 4'h4, 4'h4, 4'h8};

    // Power-on reset
    #1 rst_n = 0;
    #2 chk_en = 1;
    chk("por_sys_reset", 32'(sys_reset_o), 32'd1);
    chk("por_d_valid", 32'(d_valid), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    count_high(n);
    chk("por_hold_len", 32'(n), 32'd17);
    tl_xfer(3'd4, 4'h0, 32'h0, rop, rden, rdata);
    chk("por_cause", rdata, 32'h1);

    // Single-cycle hardware request pulse
    req_i = 2'b01;
    tick();
    req_i = 2'b00;
    chk("pulse_edge_n", 32'(sys_reset_o), 32'd0);
    tick();
    chk("pulse_edge_n1", 32'(sys_reset_o), 32'd0);
    tick();
    count_high(n);
    chk("pulse_hold_len", 32'(n), 32'd17);

    // Register access table
    for (int i = 0; i < 13; i++) begin
      tl_xfer(tbl[i].op, tbl[i].addr, tbl[i].data, rop, rden, rdata);
      chk($sformatf("tbl%0d_opcode", i), 32'(rop), 32'(tbl[i].e_op));
      chk($sformatf("tbl%0d_denied", i), 32'(rden), 32'(tbl[i].e_den));
      chk($sformatf("tbl%0d_data", i), rdata, tbl[i].e_data);
    end
    chk("tbl_no_reset", 32'(sys_reset_o), 32'd0);

    // Long request: reset extends until the request drains through the synchroniser
    req_i = 2'b10;
    repeat (40) tick();
    req_i = 2'b00;
    tick(); chk("long_fall_1", 32'(sys_reset_o), 32'd1);
    tick(); chk("long_fall_2", 32'(sys_reset_o), 32'd1);
    tick(); chk("long_fall_3", 32'(sys_reset_o), 32'd0);
    tl_xfer(3'd4, 4'h0, 32'h0, rop, rden, rdata);
    chk("long_cause", rdata, 32'h4);

    // Software trigger
    tl_xfer(3'd0, 4'h4, 32'h5A, rop, rden, rdata);
    chk("sw_ack_opcode", 32'(rop), 32'd0);
    chk("sw_ack_denied", 32'(rden), 32'd0);
    count_high(n);
    chk("sw_hold_len", 32'(n), 32'd17);
    tl_xfer(3'd4, 4'h0, 32'h0, rop, rden, rdata);
    chk("sw_cause", rdata, 32'hC);
    tl_xfer(3'd0, 4'h4, 32'h5B, rop, rden, rdata);
    n = 0;
    repeat (20) begin tick(); if (sys_reset_o) n++; end
    chk("sw_bad_key_no_reset", 32'(n), 32'd0);

    // W1C clear in the same cycle a synchronised request sets bit 1
    req_i = 2'b01;
    tick();
    req_i = 2'b00;
    tick();
    a_opcode = 3'd0; a_address = 4'h0; a_data = 32'hF; a_valid = 1; d_ready = 1;
    tick();
    a_valid = 0;
    tl_xfer(3'd4, 4'h0, 32'h0, rop, rden, rdata);
    chk("w1c_set_wins", rdata, 32'h2);

    // Back-pressured denied Get
    tick();
    a_opcode = 3'd4; a_address = 4'h8; a_data = 32'h0; a_valid = 1; d_ready = 0;
    tick();
    a_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_d_valid", 32'(d_valid), 32'd1);
      chk("stall_d_denied", 32'(d_denied), 32'd1);
      chk("stall_d_data", d_data, 32'h0);
      chk("stall_a_ready", 32'(a_ready), 32'd0);
      tick();
    end
    d_ready = 1;
    chk("stall_end_valid", 32'(d_valid), 32'd1);
    tick();
    chk("stall_done", 32'(d_valid), 32'd0);

    // Asynchronous reset mid-run
    #1 rst_n = 0;
    #1 chk("async_sys_reset", 32'(sys_reset_o), 32'd1);
    chk("async_d_valid", 32'(d_valid), 32'd0);
    repeat (3) tick();
    rst_n = 1;
    count_high(n);
    chk("async_hold_len", 32'(n), 32'd17);
    tl_xfer(3'd4, 4'h0, 32'h0, rop, rden, rdata);
    chk("async_cause", rdata, 32'h1);

    // Randomized traffic against the reference model
    hold_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold_cnt == 0) begin
        if ($urandom_range(0, 19) == 0) begin
          req_i = 2'($urandom_range(1, 3));
          hold_cnt = int'($urandom_range(1, 30));
        end else req_i = 2'b00;
      end else hold_cnt--;
      a_valid   = ($urandom_range(0, 2) == 0);
      a_opcode  = ops[$urandom_range(0, 5)];
      a_address = ($urandom_range(0, 7) == 0) ? 4'($urandom) : addrs[$urandom_range(0, 3)];
      a_data    = ($urandom_range(0, 3) == 0) ? 32'h5A : $urandom;
      a_size    = 4'($urandom);
      a_source  = 4'($urandom);
      d_ready   = ($urandom_range(0, 3) != 0);
      tick();
    end
    a_valid = 0; req_i = 2'b00; d_ready = 1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
